// File: rtl/acs_butterfly.sv
// Registered add-compare-select butterfly for a hard-decision Viterbi decoder.
// Produces two successor path metrics and survivor decisions one cycle after each valid symbol.
module acs_butterfly #(
    parameter int PM_W         = 8,
    parameter int IS_BFLY0     = 0,
    parameter int INIT_PENALTY = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            sof,
    input  logic            norm_in,
    input  logic [PM_W-1:0] pm0_in,
    input  logic [PM_W-1:0] pm1_in,
    input  logic [1:0]      p0_bm0,
    input  logic [1:0]      p0_bm1,
    input  logic [1:0]      p1_bm0,
    input  logic [1:0]      p1_bm1,
    output logic            out_valid,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            pm_msb
);

    localparam logic [PM_W-1:0] PENALTY = PM_W'(INIT_PENALTY);

    logic            out_valid_q;
    logic [PM_W-1:0] pm_lo_q, pm_lo_d;
    logic [PM_W-1:0] pm_hi_q, pm_hi_d;
    logic            dec_lo_q, dec_lo_d;
    logic            dec_hi_q, dec_hi_d;

    logic [PM_W-1:0] e0, e1;
    logic [PM_W-1:0] a0, b0, a1, b1;
    logic [PM_W-1:0] sel_lo, sel_hi;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + (PM_W+1)'(bm);
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    // Subtracting 2^(PM_W-1) with a floor of zero is just clearing the MSB, or zero if it was clear.
    function automatic logic [PM_W-1:0] norm_sub(input logic [PM_W-1:0] x);
        return x[PM_W-1] ? {1'b0, x[PM_W-2:0]} : '0;
    endfunction

    always_comb begin
        e0       = pm0_in;
        e1       = pm1_in;
        if (sof) begin
            e0 = (IS_BFLY0 != 0) ? '0 : PENALTY;
            e1 = PENALTY;
        end

        a0       = sat_add(e0, p0_bm0);
        b0       = sat_add(e1, p1_bm0);
        a1       = sat_add(e0, p0_bm1);
        b1       = sat_add(e1, p1_bm1);

        dec_lo_d = (b0 < a0);
        dec_hi_d = (b1 < a1);
        sel_lo   = dec_lo_d ? b0 : a0;
        sel_hi   = dec_hi_d ? b1 : a1;

        pm_lo_d  = norm_in ? norm_sub(sel_lo) : sel_lo;
        pm_hi_d  = norm_in ? norm_sub(sel_hi) : sel_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pm_lo_q     <= '0;
            pm_hi_q     <= '0;
            dec_lo_q    <= 1'b0;
            dec_hi_q    <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                pm_lo_q  <= pm_lo_d;
                pm_hi_q  <= pm_hi_d;
                dec_lo_q <= dec_lo_d;
                dec_hi_q <= dec_hi_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign pm_lo     = pm_lo_q;
    assign pm_hi     = pm_hi_q;
    assign dec_lo    = dec_lo_q;
    assign dec_hi    = dec_hi_q;
    assign pm_msb    = pm_lo_q[PM_W-1] & pm_hi_q[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly: two instances (start-state and ordinary butterfly)
// share one stimulus stream and are checked against an integer model every cycle.
module tb_acs_butterfly;

    localparam int PM_W    = 8;
    localparam int PENALTY = 32;
    localparam int MAXV    = (1 << PM_W) - 1;
    localparam int HALFV   = 1 << (PM_W - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, sof = 1'b0, norm_in = 1'b0;
    logic [PM_W-1:0] pm0_in = '0, pm1_in = '0;
    logic [1:0]      p0_bm0 = '0, p0_bm1 = '0, p1_bm0 = '0, p1_bm1 = '0;

    logic            ov1, dl1, dh1, msb1;
    logic [PM_W-1:0] lo1, hi1;
    logic            ov0, dl0, dh0, msb0;
    logic [PM_W-1:0] lo0, hi0;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    always #5 clk = ~clk;

    acs_butterfly #(.PM_W(PM_W), .IS_BFLY0(1), .INIT_PENALTY(PENALTY)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .norm_in(norm_in),
        .pm0_in(pm0_in), .pm1_in(pm1_in),
        .p0_bm0(p0_bm0), .p0_bm1(p0_bm1), .p1_bm0(p1_bm0), .p1_bm1(p1_bm1),
        .out_valid(ov1), .pm_lo(lo1), .pm_hi(hi1), .dec_lo(dl1), .dec_hi(dh1), .pm_msb(msb1)
    );

    acs_butterfly #(.PM_W(PM_W), .IS_BFLY0(0), .INIT_PENALTY(PENALTY)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .norm_in(norm_in),
        .pm0_in(pm0_in), .pm1_in(pm1_in),
        .p0_bm0(p0_bm0), .p0_bm1(p0_bm1), .p1_bm0(p1_bm0), .p1_bm1(p1_bm1),
        .out_valid(ov0), .pm_lo(lo0), .pm_hi(hi0), .dec_lo(dl0), .dec_hi(dh0), .pm_msb(msb0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic straight from the ACS rules.
    function automatic void acs_model(input bit start_state, input bit s, input bit n,
                                      input int m0, input int m1,
                                      input int q00, input int q01, input int q10, input int q11,
                                      output int lo, output int hi, output bit dlo, output bit dhi);
        int e0, e1, a0, b0, a1, b1;
        e0 = s ? (start_state ? 0 : PENALTY) : m0;
        e1 = s ? PENALTY : m1;
        a0 = (e0 + q00 > MAXV) ? MAXV : e0 + q00;
        a1 = (e0 + q01 > MAXV) ? MAXV : e0 + q01;
        b0 = (e1 + q10 > MAXV) ? MAXV : e1 + q10;
        b1 = (e1 + q11 > MAXV) ? MAXV : e1 + q11;
        dlo = (b0 < a0);
        dhi = (b1 < a1);
        lo  = dlo ? b0 : a0;
        hi  = dhi ? b1 : a1;
        if (n) begin
            lo = (lo - HALFV < 0) ? 0 : lo - HALFV;
            hi = (hi - HALFV < 0) ? 0 : hi - HALFV;
        end
    endfunction

    int e1_lo = 0, e1_hi = 0, e0_lo = 0, e0_hi = 0;
    bit e1_v = 0, e1_dl = 0, e1_dh = 0, e0_v = 0, e0_dl = 0, e0_dh = 0;

    always @(posedge clk) begin
        if (rst) begin
            e1_v = 0; e1_lo = 0; e1_hi = 0; e1_dl = 0; e1_dh = 0;
            e0_v = 0; e0_lo = 0; e0_hi = 0; e0_dl = 0; e0_dh = 0;
        end else begin
            e1_v = in_valid;
            e0_v = in_valid;
            if (in_valid) begin
                acs_model(1'b1, sof, norm_in, int'(pm0_in), int'(pm1_in), int'(p0_bm0),
                          int'(p0_bm1), int'(p1_bm0), int'(p1_bm1), e1_lo, e1_hi, e1_dl, e1_dh);
                acs_model(1'b0, sof, norm_in, int'(pm0_in), int'(pm1_in), int'(p0_bm0),
                          int'(p0_bm1), int'(p1_bm0), int'(p1_bm1), e0_lo, e0_hi, e0_dl, e0_dh);
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("b1.out_valid", int'(ov1), int'(e1_v));
            chk("b1.pm_lo", int'(lo1), e1_lo);
            chk("b1.pm_hi", int'(hi1), e1_hi);
            chk("b1.dec_lo", int'(dl1), int'(e1_dl));
            chk("b1.dec_hi", int'(dh1), int'(e1_dh));
            chk("b1.pm_msb", int'(msb1), int'((e1_lo >= HALFV) && (e1_hi >= HALFV)));
            chk("b0.out_valid", int'(ov0), int'(e0_v));
            chk("b0.pm_lo", int'(lo0), e0_lo);
            chk("b0.pm_hi", int'(hi0), e0_hi);
            chk("b0.dec_lo", int'(dl0), int'(e0_dl));
            chk("b0.dec_hi", int'(dh0), int'(e0_dh));
            chk("b0.pm_msb", int'(msb0), int'((e0_lo >= HALFV) && (e0_hi >= HALFV)));
        end
    end

    // Drive one cycle of inputs, let the edge capture them, then settle just after the edge.
    task automatic step(input bit r, input bit v, input bit s, input bit n,
                        input int m0, input int m1,
                        input int q00, input int q01, input int q10, input int q11);
        rst      = r;
        in_valid = v;
        sof      = s;
        norm_in  = n;
        pm0_in   = PM_W'(m0);
        pm1_in   = PM_W'(m1);
        p0_bm0   = 2'(q00);
        p0_bm1   = 2'(q01);
        p1_bm0   = 2'(q10);
        p1_bm1   = 2'(q11);
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input bit r, input bit v);
        step(r, v, 1'($urandom), 1'($urandom), int'($urandom_range(0, MAXV)),
             int'($urandom_range(0, MAXV)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        running = 1'b1;

        step_rand(1, 1);
        step_rand(1, 1);
        chk("rst out_valid", int'(ov1), 0);
        chk("rst pm_lo", int'(lo1), 0);
        chk("rst pm_hi", int'(hi1), 0);
        chk("rst dec", int'({dl1, dh1}), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post-rst no valid", int'(ov1), 0);

        step(0, 1, 1, 0, 99, 99, 0, 2, 1, 1);
        chk("sof b1 valid", int'(ov1), 1);
        chk("sof b1 pm_lo", int'(lo1), 0);
        chk("sof b1 pm_hi", int'(hi1), 2);
        chk("sof b1 dec", int'({dl1, dh1}), 0);
        chk("sof b0 pm_lo", int'(lo0), 32);
        chk("sof b0 pm_hi", int'(hi0), 33);
        chk("sof b0 dec", int'({dl0, dh0}), 1);

        step(0, 1, 0, 0, 10, 7, 2, 0, 1, 1);
        chk("sel pm_lo", int'(lo1), 8);
        chk("sel pm_hi", int'(hi1), 8);
        chk("sel dec", int'({dl1, dh1}), 3);

        step(0, 1, 0, 0, 5, 4, 1, 0, 2, 1);
        chk("tie pm_lo", int'(lo1), 6);
        chk("tie dec_lo", int'(dl1), 0);

        step(0, 1, 0, 0, 254, 255, 2, 0, 1, 1);
        chk("sat pm_lo", int'(lo1), 255);
        chk("sat dec_lo", int'(dl1), 0);
        chk("sat pm_hi", int'(hi1), 254);
        chk("sat pm_msb", int'(msb1), 1);

        step(0, 1, 0, 1, 200, 150, 0, 0, 0, 0);
        chk("norm pm_lo", int'(lo1), 22);
        chk("norm pm_hi", int'(hi1), 22);
        chk("norm dec", int'({dl1, dh1}), 3);

        step(0, 1, 0, 1, 255, 255, 1, 1, 1, 1);
        chk("norm sat pm_lo", int'(lo1), 127);

        step(0, 1, 0, 1, 100, 100, 0, 0, 0, 0);
        chk("norm clamp pm_lo", int'(lo1), 0);

        step(0, 1, 1, 1, 200, 200, 3, 3, 3, 3);
        chk("norm sof b0 pm_lo", int'(lo0), 0);

        step(0, 1, 0, 0, 12, 30, 1, 2, 3, 0);
        step(0, 1, 0, 0, 60, 50, 3, 3, 0, 0);
        step(0, 1, 0, 0, 130, 129, 0, 1, 2, 3);
        step(0, 1, 0, 0, 40, 41, 3, 0, 0, 3);
        step(0, 0, 0, 0, 1, 2, 1, 1, 1, 1);
        step(0, 0, 1, 1, 3, 4, 2, 2, 2, 2);
        step(0, 0, 0, 0, 5, 6, 3, 3, 3, 3);
        chk("hold out_valid", int'(ov1), 0);
        chk("hold pm_lo", int'(lo1), 41);
        chk("hold pm_hi", int'(hi1), 40);
        chk("hold dec", int'({dl1, dh1}), 2);

        step(0, 1, 0, 0, 70, 80, 2, 1, 0, 3);
        step(0, 1, 0, 0, 90, 20, 1, 1, 1, 1);
        step(1, 1, 0, 0, 33, 44, 1, 2, 3, 0);
        chk("mid rst valid", int'(ov1), 0);
        chk("mid rst pm", int'({lo1, hi1}), 0);

        for (int i = 0; i < 40; i++) step_rand(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
